alu_arbiter: RTL and testbench

Shares one pipelined ALU between `NUM_REQ` requesters. It sits between the requester ports and the ALU's `valid_in/a/b/cin/ctl` inputs and `valid_out/alu/carry/zero` outputs. Grants are round-robin, one per cycle. The arbiter records the requester ID of each in-flight operation in an in-order ID FIFO, so every ALU result returns to the requester that issued it. A drain state machine quiesces the ALU on request.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among several requesters.
// An in-order ID FIFO routes each ALU result back to the requester that issued it.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CTL_W   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    input  logic [NUM_REQ*CTL_W-1:0]  req_ctl,
    output logic                      valid_in,
    output logic [DATA_W-1:0]         a,
    output logic [DATA_W-1:0]         b,
    output logic                      cin,
    output logic [CTL_W-1:0]          ctl,
    input  logic                      valid_out,
    input  logic [DATA_W-1:0]         alu,
    input  logic                      carry,
    input  logic                      zero,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_carry,
    output logic                      rsp_zero,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_spurious
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] gnt_id;
    logic          gnt_any;
    logic          issue_ok;
    logic          run_st;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    logic [PW-1:0] fifo [MAX_OUT];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0) state_nxt = IDLE;
            IDLE:    if (!drain_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run_st     = (state == RUN);
        drain_done = (state == IDLE);
    end

    // A pop in the same cycle does not free a credit for this cycle's grant.
    assign issue_ok = reset && run_st && (outstanding < OW'(MAX_OUT));

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!gnt_any && issue_ok && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign ptr_nxt   = (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + PW'(1);
    assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign pop       = valid_out && (outstanding != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            valid_in <= 1'b0;
            a        <= '0;
            b        <= '0;
            cin      <= 1'b0;
            ctl      <= '0;
        end else begin
            valid_in <= gnt_any;
            if (gnt_any) begin
                ptr <= ptr_nxt;
                a   <= req_a[int'(gnt_id)*DATA_W +: DATA_W];
                b   <= req_b[int'(gnt_id)*DATA_W +: DATA_W];
                cin <= req_cin[gnt_id];
                ctl <= req_ctl[int'(gnt_id)*CTL_W +: CTL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) fifo[wr_ptr] <= gnt_id;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            err_spurious <= 1'b0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            if (gnt_any) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (gnt_any && !pop) begin
                outstanding <= outstanding + OW'(1);
            end else if (!gnt_any && pop) begin
                outstanding <= outstanding - OW'(1);
            end
            if (valid_out && !pop) err_spurious <= 1'b1;
            rsp_valid <= pop ? (NUM_REQ'(1) << fifo[rd_ptr]) : '0;
            if (pop) begin
                rsp_data  <= alu;
                rsp_carry <= carry;
                rsp_zero  <= zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stallable in-order ALU model
// and a scoreboard of expected results keyed by requester.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_cin;
    logic [15:0] req_ctl;
    logic        valid_in;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [3:0]  ctl;
    logic        valid_out = 1'b0;
    logic [7:0]  alu = '0;
    logic        carry = 1'b0;
    logic        zero = 1'b0;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        drain_req;
    logic        drain_done;
    logic [2:0]  outstanding;
    logic        err_spurious;

    int tests = 0;
    int failed = 0;

    logic stall = 1'b0;
    logic release_one = 1'b0;
    logic spur = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [3:0] ctl;
    } op_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
        logic       c;
        logic       z;
    } exp_t;

    op_t  mq[$];
    exp_t sb[$];
    op_t  m_op;
    logic [9:0] m_r;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctl(req_ctl),
        .valid_in(valid_in), .a(a), .b(b), .cin(cin), .ctl(ctl),
        .valid_out(valid_out), .alu(alu), .carry(carry), .zero(zero),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .drain_req(drain_req), .drain_done(drain_done),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {zero, carry, result}: 0=ADD, 1=AND, 2=XOR, else OR.
    function automatic logic [9:0] calc(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input logic [3:0] op);
        logic [8:0] s;
        s = '0;
        case (op)
            4'd0:    s = {1'b0, x} + {1'b0, y} + {8'd0, ci};
            4'd1:    s = {1'b0, x & y};
            4'd2:    s = {1'b0, x ^ y};
            default: s = {1'b0, x | y};
        endcase
        return {(s[7:0] == 8'd0), s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic [3:0] op);
        req_a[i*8 +: 8]   = x;
        req_b[i*8 +: 8]   = y;
        req_cin[i]        = ci;
        req_ctl[i*4 +: 4] = op;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || outstanding != 3'd0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_out"}, 32'(outstanding), 32'd0);
        chk({tag, "_idle_sb"}, 32'(sb.size()), 32'd0);
    endtask

    // ALU model: one-cycle latency from valid_in, frozen while stalled.
    always @(posedge clk) begin
        if (valid_in) mq.push_back('{a, b, cin, ctl});
        valid_out <= 1'b0;
        if (spur) begin
            valid_out <= 1'b1;
            alu       <= 8'hAA;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else if ((!stall || release_one) && mq.size() > 0) begin
            m_op = mq.pop_front();
            m_r  = calc(m_op.a, m_op.b, m_op.cin, m_op.ctl);
            valid_out <= 1'b1;
            alu       <= m_r[7:0];
            carry     <= m_r[8];
            zero      <= m_r[9];
        end
    end

    // Scoreboard push on every handshake.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m_r = calc(req_a[i*8 +: 8], req_b[i*8 +: 8], req_cin[i], req_ctl[i*4 +: 4]);
                    sb.push_back('{2'(i), m_r[7:0], m_r[8], m_r[9]});
                end
            end
        end
    end

    // Scoreboard pop on every response strobe.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] oh;
        if (reset && rsp_valid != 4'd0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.id;
                chk("sb_valid", 32'(rsp_valid), 32'(oh));
                chk("sb_data", 32'(rsp_data), 32'(e.d));
                chk("sb_carry", 32'(rsp_carry), 32'(e.c));
                chk("sb_zero", 32'(rsp_zero), 32'(e.z));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int cnt;
        reset     = 1'b0;
        req_valid = 4'hF;
        drain_req = 1'b0;
        req_a = '0; req_b = '0; req_cin = '0; req_ctl = '0;
        set_op(0, 8'h12, 8'h34, 1'b1, 4'd0);
        set_op(1, 8'hF0, 8'h3C, 1'b0, 4'd1);
        set_op(2, 8'h55, 8'h55, 1'b0, 4'd2);
        set_op(3, 8'hFF, 8'h01, 1'b0, 4'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid_in", 32'(valid_in), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_cin", 32'(cin), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_out", 32'(outstanding), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_err", 32'(err_spurious), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fairness: all four requesting, grants rotate 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_gnt", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
        end
        req_valid = 4'h0;
        wait_idle("fair");

        // Single op from requester 2
        @(negedge clk);
        set_op(2, 8'h0F, 8'h01, 1'b0, 4'd0);
        req_valid = 4'b0100;
        #1;
        chk("single_gnt", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'h0;
        chk("single_vin", 32'(valid_in), 32'd1);
        chk("single_a", 32'(a), 32'h0F);
        chk("single_b", 32'(b), 32'h01);
        chk("single_ctl", 32'(ctl), 32'd0);
        @(negedge clk);
        chk("single_vin_pulse", 32'(valid_in), 32'd0);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", 32'(rsp_data), 32'h10);
        chk("single_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("single_rsp_zero", 32'(rsp_zero), 32'd0);
        @(negedge clk);
        chk("single_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("single_a_hold", 32'(a), 32'h0F);
        wait_idle("single");

        // Credit limit with stalled ALU
        stall = 1'b1;
        req_valid = 4'hF;
        g = 0;
        repeat (6) begin
            #1;
            if (req_ready != 4'd0) g++;
            @(negedge clk);
        end
        chk("credit_grants", 32'(g), 32'd4);
        chk("credit_out", 32'(outstanding), 32'd4);
        #1;
        chk("credit_ready", 32'(req_ready), 32'd0);
        release_one = 1'b1;
        @(negedge clk);
        release_one = 1'b0;
        #1;
        chk("credit_pop_cycle", 32'(req_ready), 32'd0);
        g = 0;
        repeat (5) begin
            #1;
            if (req_ready != 4'd0) g++;
            @(negedge clk);
        end
        chk("credit_one_more", 32'(g), 32'd1);
        chk("credit_out2", 32'(outstanding), 32'd4);
        req_valid = 4'h0;
        stall = 1'b0;
        wait_idle("credit");

        // Drain with three ops in flight
        stall = 1'b1;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        req_valid = 4'h0;
        drain_req = 1'b1;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("drain_nogrant", 32'(req_ready), 32'd0);
        chk("drain_out", 32'(outstanding), 32'd3);
        chk("drain_not_done", 32'(drain_done), 32'd0);
        stall = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20 && cnt < 3; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 4'd0) cnt++;
            if (cnt < 3) chk("drain_nogrant_loop", 32'(req_ready), 32'd0);
        end
        chk("drain_results", 32'(cnt), 32'd3);
        chk("drain_done_early", 32'(drain_done), 32'd0);
        @(negedge clk);
        #1;
        chk("drain_done", 32'(drain_done), 32'd1);
        chk("drain_idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        drain_req = 1'b0;
        #1;
        chk("drain_hold", 32'(req_ready), 32'd0);
        chk("drain_done_hold", 32'(drain_done), 32'd1);
        @(negedge clk);
        #1;
        chk("drain_resume", 32'(req_ready != 4'd0), 32'd1);
        chk("drain_done_clear", 32'(drain_done), 32'd0);
        req_valid = 4'h0;
        wait_idle("drain");

        // Spurious result with nothing in flight
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_err_pre", 32'(err_spurious), 32'd0);
        @(negedge clk);
        chk("spur_err", 32'(err_spurious), 32'd1);
        chk("spur_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("spur_sticky", 32'(err_spurious), 32'd1);

        // Mid-operation reset with two ops in flight
        stall = 1'b1;
        req_valid = 4'b0011;
        repeat (2) @(negedge clk);
        req_valid = 4'h0;
        repeat (2) @(negedge clk);
        chk("mid_out_pre", 32'(outstanding), 32'd2);
        reset = 1'b0;
        req_valid = 4'hF;
        sb.delete();
        #1;
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_valid_in", 32'(valid_in), 32'd0);
        chk("mid_a", 32'(a), 32'd0);
        chk("mid_ctl", 32'(ctl), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_out", 32'(outstanding), 32'd0);
        chk("mid_err", 32'(err_spurious), 32'd0);
        chk("mid_drain_done", 32'(drain_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'h0;
        stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_stale_err", 32'(err_spurious), 32'd1);
        chk("mid_stale_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_stale_out", 32'(outstanding), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("mid_ptr0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'h0;
        wait_idle("mid");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
